// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with bounded grant tenure
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [4:0] hold_q, hold_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] id_q, id_d;

    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    logic       release_now;

    // Priority scan starts at ptr_q and wraps naturally through 3-bit addition.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign release_now = !req[id_q] || !enable || (hold_q >= HOLD_MAX);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    state_d = BUSY;
                    grant_d = 8'd1 << win;
                    id_d    = win;
                    hold_d  = 5'd1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    hold_d  = '0;
                    ptr_d   = id_q + 3'd1;
                end else begin
                    hold_d  = hold_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            id_q    <= id_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign grant_valid = (state_q == BUSY);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed vector bench for rr_arbiter_8 (MAX_HOLD=16 and MAX_HOLD=1)
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;

    logic [7:0] grant_a, grant_b;
    logic [2:0] id_a, id_b;
    logic       v_a, v_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit inv_on = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .grant(grant_a), .grant_id(id_a), .grant_valid(v_a)
    );

    rr_arbiter_8 #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .grant(grant_b), .grant_id(id_b), .grant_valid(v_b)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] req;
        logic       av;
        logic [2:0] aid;
        logic       bv;
        logic [2:0] bid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] rq,
                       input logic av, input int aid, input logic bv, input int bid);
        vec_t v;
        v.rst_n = r;
        v.en    = e;
        v.req   = rq;
        v.av    = av;
        v.aid   = 3'(aid);
        v.bv    = bv;
        v.bid   = 3'(bid);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] enc(input logic [7:0] g);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic expect_both(input string tag, input logic av, input logic [2:0] aid,
                               input logic bv, input logic [2:0] bid);
        logic [7:0] ga, gb;
        ga = av ? (8'd1 << aid) : 8'h00;
        gb = bv ? (8'd1 << bid) : 8'h00;
        check({tag, " grant_a"}, 32'(grant_a), 32'(ga));
        check({tag, " id_a"},    32'(id_a),    av ? 32'(aid) : 32'd0);
        check({tag, " valid_a"}, 32'(v_a),     32'(av));
        check({tag, " grant_b"}, 32'(grant_b), 32'(gb));
        check({tag, " id_b"},    32'(id_b),    bv ? 32'(bid) : 32'd0);
        check({tag, " valid_b"}, 32'(v_b),     32'(bv));
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (inv_on) begin
            check("onehot_a", 32'($countones(grant_a) <= 1), 32'd1);
            check("enc_a",    32'(id_a), 32'(enc(grant_a)));
            check("gv_a",     32'(v_a),  32'(grant_a != 8'h00));
            check("onehot_b", 32'($countones(grant_b) <= 1), 32'd1);
            check("enc_b",    32'(id_b), 32'(enc(grant_b)));
            check("gv_b",     32'(v_b),  32'(grant_b != 8'h00));
        end
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        req    = 8'h00;

        // req=FF: a holds requester 0 for 16 cycles; b rotates 0,-,1,-,...,7,-,0
        add(0, 1, 8'hFF, 0, 0, 0, 0);
        for (int e = 1; e <= 18; e++)
            add(1, 1, 8'hFF, (e != 17), (e <= 16) ? 0 : 1, (e % 2 == 1), ((e - 1) / 2) % 8);
        add(0, 1, 8'hFF, 0, 0, 0, 0);

        // Single requester 0: 16-cycle tenure, one IDLE, re-grant
        for (int e = 1; e <= 18; e++)
            add(1, 1, 8'h01, (e != 17), 0, (e % 2 == 1), 0);
        add(0, 1, 8'h01, 0, 0, 0, 0);

        // Pointer to 5, then wrap to requester 2
        add(1, 1, 8'h10, 1, 4, 1, 4);
        add(1, 1, 8'h00, 0, 0, 0, 0);
        add(1, 1, 8'h24, 1, 5, 1, 5);
        add(1, 1, 8'h04, 0, 0, 0, 0);
        add(1, 1, 8'h04, 1, 2, 1, 2);
        add(1, 1, 8'h04, 1, 2, 0, 0);
        add(1, 1, 8'h04, 1, 2, 1, 2);
        add(0, 1, 8'h04, 0, 0, 0, 0);

        // Enable drop during tenure on 3, then other-request changes mid-tenure
        add(1, 1, 8'h08, 1, 3, 1, 3);
        add(1, 0, 8'h08, 0, 0, 0, 0);
        add(1, 0, 8'hFF, 0, 0, 0, 0);
        add(1, 0, 8'hFF, 0, 0, 0, 0);
        add(1, 1, 8'hFF, 1, 4, 1, 4);
        add(1, 1, 8'h10, 1, 4, 0, 0);
        add(1, 1, 8'h1F, 1, 4, 1, 0);
        add(0, 1, 8'h1F, 0, 0, 0, 0);

        // Reset during tenure on 6
        add(1, 1, 8'h40, 1, 6, 1, 6);
        add(1, 1, 8'h40, 1, 6, 0, 0);
        add(0, 1, 8'hFF, 0, 0, 0, 0);
        add(1, 1, 8'hFF, 1, 0, 1, 0);

        @(posedge clk);
        #1;
        inv_on = 1'b1;
        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            enable = vecs[i].en;
            req    = vecs[i].req;
            @(posedge clk);
            #1;
            expect_both($sformatf("vec%0d", i), vecs[i].av, vecs[i].aid, vecs[i].bv, vecs[i].bid);
        end

        // Reset pulse between edges must be ignored
        rst_n  = 1'b1;
        enable = 1'b1;
        req    = 8'hFF;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_both("glitch1", 1'b1, 3'd0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        expect_both("glitch2", 1'b1, 3'd0, 1'b1, 3'd1);

        // Reset held low ignores enable/req across several edges
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = 8'(8'h5A << k);
            @(posedge clk);
            #1;
            expect_both($sformatf("rst_hold%0d", k), 1'b0, 3'd0, 1'b0, 3'd0);
        end

        inv_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive grant cycles per tenure; legal range 1..31.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-004 enable  input  1  SHALL be the arbitration enable; low blocks new grants and ends any current tenure.
REQ-005 req  input  8  SHALL carry one request bit per requester; bit i belongs to requester i.
REQ-006 grant  output  8  SHALL be the registered grant, one-hot or all-zero.
REQ-007 grant_id  output  3  SHALL be the binary index of the set grant bit; 0 when grant is zero.
REQ-008 grant_valid  output  1  SHALL be high exactly when grant is non-zero.

Function
REQ-009 The block SHALL have two states: IDLE (no grant) and BUSY (one grant held).
REQ-010 The block SHALL keep a 3-bit round-robin pointer ptr that names the highest-priority requester.
REQ-011 In IDLE with enable=1 and req!=0, the block SHALL pick the first set req bit scanning ptr, ptr+1, ..., wrapping 7->0.
REQ-012 After a pick, the next edge SHALL move to BUSY, set grant to the winner one-hot, set grant_id and grant_valid, and load hold_cnt=1.
REQ-013 Grant latency SHALL be one cycle: a req sampled at edge N in IDLE is visible on grant after edge N.
REQ-014 In IDLE with enable=0 or req==0, the block SHALL stay in IDLE with all outputs zero and ptr unchanged.
REQ-015 In BUSY, the tenure SHALL continue while req[grant_id]=1, enable=1 and hold_cnt<MAX_HOLD, incrementing hold_cnt each edge.
REQ-016 In BUSY, the block SHALL release when any of these holds: req[grant_id]=0, enable=0, or hold_cnt==MAX_HOLD.
REQ-017 On release, the next edge SHALL clear grant, grant_id and grant_valid, set ptr=grant_id+1 mod 8, and enter IDLE.
REQ-018 Every tenure SHALL be followed by at least one IDLE cycle; there are no back-to-back grants.
REQ-019 Changes to req bits other than req[grant_id] during BUSY SHALL NOT affect the current grant.
REQ-020 With MAX_HOLD=1, each tenure SHALL last exactly one cycle.
REQ-021 A requester that holds req continuously SHALL be re-granted only after every other active requester has had one tenure (fairness).
REQ-022 grant SHALL never have more than one bit set, in any cycle.
REQ-023 grant_id SHALL always equal the encoded index of grant.

Reset
REQ-024 With rst_n=0 at an edge, the block SHALL enter IDLE and clear grant=0, grant_id=0, grant_valid=0, ptr=0 and hold_cnt=0.
REQ-025 Reset SHALL win over every other input, including during BUSY; the grant drops after that edge.
REQ-026 While rst_n=0, outputs SHALL stay zero regardless of req and enable.
REQ-027 Reset SHALL have no effect between clock edges (synchronous only).

Verification
REQ-028 Reset, enable=1, req=8'b0000_0001 held -> grant=8'h01, grant_id=0 one cycle later; with MAX_HOLD=16, release after 16 grant cycles; 1 IDLE cycle; re-grant to 0.
REQ-029 Reset, enable=1, req=8'hFF held, MAX_HOLD=1 -> grant_id sequence 0,-,1,-,2,...,7,-,0 ('-' = IDLE, grant_valid=0).
REQ-030 ptr=5, req=8'b0010_0100 -> grant_id=5; drop req[5] -> release, ptr=6; next grant wraps to grant_id=2.
REQ-031 BUSY on requester 3, enable driven low for one cycle -> grant=0 the next edge, ptr=4; with enable=0, req=8'hFF yields no grant.
REQ-032 BUSY on requester 6, rst_n=0 for one edge -> grant=0, grant_id=0, ptr=0; after rst_n=1 with req=8'hFF, grant_id=0.
REQ-033 A bench checker SHALL assert REQ-022 and REQ-023 every cycle, and SHALL check grant_valid == (grant != 0).
